// File: rtl/mem_arb_pkg.sv
// Shared types for the data memory arbiter: bus owner codes, FSM states and
// the debug snapshot of the arbitration state.
package mem_arb_pkg;

  localparam int LANES  = 4;
  localparam int BEAT_W = 2;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LANES - 1);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_VGA,
    OWN_SCALAR,
    OWN_VEC
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCALAR,
    ST_VGA,
    ST_VEC
  } arb_state_e;

  typedef struct packed {
    arb_state_e        state;
    logic [BEAT_W-1:0] beat;
    logic              rr_ptr;
  } arb_dbg_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker (a = scalar, b = vector). The pointer names the
// preferred port and flips to the other port after every grant.
module rr_pick2 (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o,
  output logic ptr_o
);

  logic ptr_q, ptr_d;
  logic gnt_a, gnt_b;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    ptr_d = ptr_q;
    if (en_i) begin
      if (req_a_i && (!req_b_i || !ptr_q)) begin
        gnt_a = 1'b1;
        ptr_d = 1'b1;
      end else if (req_b_i) begin
        gnt_b = 1'b1;
        ptr_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

  assign gnt_a_o = gnt_a;
  assign gnt_b_o = gnt_b;
  assign ptr_o   = ptr_q;

endmodule

// File: rtl/data_mem_arbiter.sv
// Data memory arbiter: shares one single-port, 1-cycle-latency memory between
// VGA scan-out, the scalar core and the 4-lane vector unit.
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_req,
  input  logic                          s_we,
  input  logic [ADDR_W-1:0]             s_addr,
  input  logic [DATA_W-1:0]             s_wdata,
  output logic [DATA_W-1:0]             s_rdata,
  output logic                          s_done,
  input  logic                          v_req,
  input  logic                          v_we,
  input  logic [LANES-1:0][ADDR_W-1:0]  v_addr,
  input  logic [LANES-1:0][DATA_W-1:0]  v_wdata,
  output logic [LANES-1:0][DATA_W-1:0]  v_rdata,
  output logic                          v_done,
  input  logic                          g_req,
  input  logic [ADDR_W-1:0]             g_addr,
  output logic [DATA_W-1:0]             g_rdata,
  output logic                          g_valid,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic                          mem_we,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output arb_dbg_t                      dbg_o
);

  // Handshake: a requester raises req with its inputs stable and keeps them
  // until its done/valid pulse; that pulse is the only completion signal,
  // and a req still high in the pulse cycle is not treated as a new request.

  arb_state_e                    state_q;
  logic [BEAT_W-1:0]             beat_q;
  logic                          s_done_q, v_done_q, g_valid_q;
  logic                          s_rd_q, v_rd_q;
  logic [ADDR_W-1:0]             mem_addr_q;
  logic [DATA_W-1:0]             mem_wdata_q;
  logic [DATA_W-1:0]             s_rdata_q, g_rdata_q;
  logic [LANES-1:0][DATA_W-1:0]  v_rdata_q;
  logic [LANES-2:0][DATA_W-1:0]  v_buf_q;

  logic   final_beat, arb_en;
  logic   g_elig, s_elig, v_elig;
  logic   s_gnt, v_gnt, rr_ptr;
  owner_e grant_own;

  always_comb begin
    final_beat = (state_q == ST_SCALAR) || (state_q == ST_VGA) ||
                 ((state_q == ST_VEC) && (beat_q == LAST_BEAT));
    arb_en     = (state_q == ST_IDLE) || final_beat;
    // The current owner and any port showing its completion are excluded.
    g_elig     = g_req && !g_valid_q && (state_q != ST_VGA);
    s_elig     = s_req && !s_done_q  && (state_q != ST_SCALAR);
    v_elig     = v_req && !v_done_q  && (state_q != ST_VEC);
  end

  rr_pick2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .en_i    (arb_en && !g_elig),
    .req_a_i (s_elig),
    .req_b_i (v_elig),
    .gnt_a_o (s_gnt),
    .gnt_b_o (v_gnt),
    .ptr_o   (rr_ptr)
  );

  always_comb begin
    grant_own = OWN_NONE;
    if (arb_en) begin
      if (g_elig)     grant_own = OWN_VGA;
      else if (s_gnt) grant_own = OWN_SCALAR;
      else if (v_gnt) grant_own = OWN_VEC;
    end
  end

  always_comb begin
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    mem_we    = 1'b0;
    unique case (state_q)
      ST_SCALAR: begin
        mem_addr  = s_addr;
        mem_wdata = s_wdata;
        mem_we    = s_we;
      end
      ST_VGA: mem_addr = g_addr;
      ST_VEC: begin
        mem_addr  = v_addr[beat_q];
        mem_wdata = v_wdata[beat_q];
        mem_we    = v_we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      s_done_q  <= 1'b0;
      v_done_q  <= 1'b0;
      g_valid_q <= 1'b0;
      s_rd_q    <= 1'b0;
      v_rd_q    <= 1'b0;
    end else begin
      s_done_q  <= (state_q == ST_SCALAR);
      g_valid_q <= (state_q == ST_VGA);
      v_done_q  <= (state_q == ST_VEC) && (beat_q == LAST_BEAT);
      if (state_q == ST_SCALAR) s_rd_q <= !s_we;
      if ((state_q == ST_VEC) && (beat_q == LAST_BEAT)) v_rd_q <= !v_we;
      if (arb_en) begin
        beat_q <= '0;
        unique case (grant_own)
          OWN_VGA:    state_q <= ST_VGA;
          OWN_SCALAR: state_q <= ST_SCALAR;
          OWN_VEC:    state_q <= ST_VEC;
          default:    state_q <= ST_IDLE;
        endcase
      end else begin
        beat_q <= beat_q + 2'd1;
      end
    end
  end

  // Read data lands one cycle after its beat; lanes 0..LANES-2 wait in
  // v_buf_q so the whole vector appears together with v_done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      s_rdata_q   <= '0;
      g_rdata_q   <= '0;
      v_rdata_q   <= '0;
      v_buf_q     <= '0;
    end else begin
      mem_addr_q  <= mem_addr;
      mem_wdata_q <= mem_wdata;
      if ((state_q == ST_VEC) && (beat_q != '0)) v_buf_q[beat_q - 2'd1] <= mem_rdata;
      if (s_done_q && s_rd_q) s_rdata_q <= mem_rdata;
      if (g_valid_q)          g_rdata_q <= mem_rdata;
      if (v_done_q && v_rd_q) v_rdata_q <= {mem_rdata, v_buf_q};
    end
  end

  assign s_done  = s_done_q;
  assign v_done  = v_done_q;
  assign g_valid = g_valid_q;
  assign s_rdata = (s_done_q && s_rd_q) ? mem_rdata : s_rdata_q;
  assign g_rdata = g_valid_q ? mem_rdata : g_rdata_q;
  assign v_rdata = (v_done_q && v_rd_q) ? {mem_rdata, v_buf_q} : v_rdata_q;

  always_comb begin
    dbg_o.state  = state_q;
    dbg_o.beat   = beat_q;
    dbg_o.rr_ptr = rr_ptr;
  end

endmodule
